// File: rtl/definitions.sv
// rtl/definitions.sv - shared widths, opcode map and state encoding for the control path
package definitions;

    localparam int INSN_WIDTH = 9;
    localparam int DATA_WIDTH = 8;

    localparam int OP_MSB    = 8;
    localparam int OP_LSB    = 6;
    localparam int IMM_MSB   = 5;
    localparam int IMM_LSB   = 0;
    localparam int IMM_WIDTH = IMM_MSB - IMM_LSB + 1;

    localparam logic [2:0]           OP_JMP   = 3'b101;
    localparam logic [2:0]           OP_BRZ   = 3'b110;
    localparam logic [2:0]           OP_CTL   = 3'b111;
    localparam logic [IMM_WIDTH-1:0] HALT_IMM = 6'h3F;

    typedef enum logic [1:0] {
        BC_RUN    = 2'd0,
        BC_SQUASH = 2'd1,
        BC_HALTED = 2'd2
    } bc_state_t;

    function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] imm);
        return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

endpackage

// File: rtl/branch_control_sat_counter.sv
// rtl/branch_control_sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_control.sv
// rtl/branch_control.sv - decodes JMP/BRZ/HALT, issues registered redirect pulses and squashes the shadow slot
module branch_control
    import definitions::*;
#(
    parameter int INSN_WIDTH = definitions::INSN_WIDTH,
    parameter int DATA_WIDTH = definitions::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  _CLK,
    input  logic                  _reset,
    input  logic                  _run,
    input  logic [INSN_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] _regData,
    input  logic                  _aluZero,
    input  logic                  _flagWrite,
    output logic                  _branchJump,
    output logic                  _relative,
    output logic [DATA_WIDTH-1:0] _destBranchJump,
    output logic                  _halt,
    output logic                  _squash,
    output logic [CNT_WIDTH-1:0]  takenCount
);

    bc_state_t             state_q, state_d;
    logic                  zflag_q, zflag_d;
    logic                  branch_jump_q, branch_jump_d;
    logic                  relative_q, relative_d;
    logic [DATA_WIDTH-1:0] dest_q, dest_d;
    logic                  halt_q, halt_d;
    logic                  squash_q, squash_d;

    logic [2:0]           opcode;
    logic [IMM_WIDTH-1:0] imm6;
    logic                 is_jmp;
    logic                 is_brz;
    logic                 is_halt;
    logic                 enter_squash;

    assign opcode  = instruction[OP_MSB:OP_LSB];
    assign imm6    = instruction[IMM_MSB:IMM_LSB];
    assign is_jmp  = (opcode == OP_JMP);
    assign is_brz  = (opcode == OP_BRZ);
    assign is_halt = (opcode == OP_CTL) && (imm6 == HALT_IMM);

    // BRZ sees the flag as registered before this edge, so a same-cycle write is not visible.
    always_comb begin
        state_d = state_q;
        if (_run) begin
            case (state_q)
                BC_RUN: begin
                    if (is_jmp || (is_brz && zflag_q)) begin
                        state_d = BC_SQUASH;
                    end else if (is_halt) begin
                        state_d = BC_HALTED;
                    end
                end
                BC_SQUASH: state_d = BC_RUN;
                BC_HALTED: state_d = BC_HALTED;
                default:   state_d = BC_RUN;
            endcase
        end
    end

    assign enter_squash = _run && (state_q == BC_RUN) && (state_d == BC_SQUASH);

    always_comb begin
        zflag_d       = zflag_q;
        branch_jump_d = 1'b0;
        squash_d      = 1'b0;
        relative_d    = relative_q;
        dest_d        = dest_q;
        halt_d        = (state_d == BC_HALTED);
        if (_run) begin
            branch_jump_d = (state_d == BC_SQUASH);
            squash_d      = (state_d != BC_RUN);
            relative_d    = enter_squash && is_brz;
            if (_flagWrite && (state_q != BC_HALTED)) begin
                zflag_d = _aluZero;
            end
        end
        if (enter_squash) begin
            dest_d = is_jmp ? _regData : DATA_WIDTH'(sext_imm(imm6));
        end
    end

    always_ff @(posedge _CLK) begin
        if (!_reset) begin
            state_q       <= BC_RUN;
            zflag_q       <= 1'b0;
            branch_jump_q <= 1'b0;
            relative_q    <= 1'b0;
            dest_q        <= '0;
            halt_q        <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            zflag_q       <= zflag_d;
            branch_jump_q <= branch_jump_d;
            relative_q    <= relative_d;
            dest_q        <= dest_d;
            halt_q        <= halt_d;
            squash_q      <= squash_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_taken_cnt (
        .clk_i   (_CLK),
        .clr_i   (!_reset),
        .inc_i   (enter_squash),
        .count_o (takenCount)
    );

    assign _branchJump     = branch_jump_q;
    assign _relative       = relative_q;
    assign _destBranchJump = dest_q;
    assign _halt           = halt_q;
    assign _squash         = squash_q;

endmodule

// File: tb/tb_branch_control.sv
// tb/tb_branch_control.sv - scoreboard bench for branch_control with a narrow-counter twin
module tb_branch_control;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [8:0] insn;
    logic [7:0] reg_data;
    logic       alu_zero;
    logic       flag_write;

    logic        bj, rel, halt, sq;
    logic [7:0]  dest;
    logic [15:0] cnt;
    logic        bj2, rel2, halt2, sq2;
    logic [7:0]  dest2;
    logic [1:0]  cnt2;

    typedef struct {
        logic        bj;
        logic        rel;
        logic [7:0]  dest;
        logic        halt;
        logic        sq;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    branch_control dut (
        ._CLK            (clk),
        ._reset          (rst_n),
        ._run            (run),
        .instruction     (insn),
        ._regData        (reg_data),
        ._aluZero        (alu_zero),
        ._flagWrite      (flag_write),
        ._branchJump     (bj),
        ._relative       (rel),
        ._destBranchJump (dest),
        ._halt           (halt),
        ._squash         (sq),
        .takenCount      (cnt)
    );

    branch_control #(.CNT_WIDTH(2)) dut_sat (
        ._CLK            (clk),
        ._reset          (rst_n),
        ._run            (run),
        .instruction     (insn),
        ._regData        (reg_data),
        ._aluZero        (alu_zero),
        ._flagWrite      (flag_write),
        ._branchJump     (bj2),
        ._relative       (rel2),
        ._destBranchJump (dest2),
        ._halt           (halt2),
        ._squash         (sq2),
        .takenCount      (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic rn, input logic fw, input logic az,
                        input logic [8:0] i, input logic [7:0] rd,
                        input logic ebj, input logic erel, input logic [7:0] edest,
                        input logic ehalt, input logic esq, input int ecnt);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n      = r;
        run        = rn;
        flag_write = fw;
        alu_zero   = az;
        insn       = i;
        reg_data   = rd;
        e.bj   = ebj;
        e.rel  = erel;
        e.dest = edest;
        e.halt = ehalt;
        e.sq   = esq;
        e.cnt  = 16'(ecnt);
        e.cnt2 = (ecnt > 3) ? 2'd3 : 2'(ecnt);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bj !== e.bj || rel !== e.rel || dest !== e.dest || halt !== e.halt ||
                    sq !== e.sq || cnt !== e.cnt || cnt2 !== e.cnt2) begin
                    fails++;
                    $display("FAIL outputs t=%0t got bj=%b rel=%b dest=%h halt=%b sq=%b cnt=%0d cnt2=%0d want bj=%b rel=%b dest=%h halt=%b sq=%b cnt=%0d cnt2=%0d",
                             $time, bj, rel, dest, halt, sq, cnt, cnt2,
                             e.bj, e.rel, e.dest, e.halt, e.sq, e.cnt, e.cnt2);
                end
            end
        end
    end

    initial begin
        int budget;
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        run        = 1'b1;
        insn       = 9'h1FF;
        reg_data   = 8'd0;
        alu_zero   = 1'b0;
        flag_write = 1'b0;

        // reset and non-control decode
        step(0,1,0,0,9'h1FF,8'd0,   0,0,8'h00,0,0,0);
        step(0,1,0,0,9'h1FF,8'd0,   0,0,8'h00,0,0,0);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'h00,0,0,0);
        step(1,1,0,0,9'h1C0,8'd0,   0,0,8'h00,0,0,0);
        // absolute jump
        step(1,1,0,0,9'h140,8'd14,  1,0,8'd14,0,1,1);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'd14,0,0,1);
        // relative branch, then same-cycle write uses old flag
        step(1,1,1,1,9'h000,8'd0,   0,0,8'd14,0,0,1);
        step(1,1,0,0,9'h1BD,8'd0,   1,1,8'hFD,0,1,2);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'hFD,0,0,2);
        step(1,1,1,0,9'h1BD,8'd0,   1,1,8'hFD,0,1,3);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'hFD,0,0,3);
        step(1,1,0,0,9'h185,8'd0,   0,0,8'hFD,0,0,3);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'hFD,0,0,3);
        // squash shadow drops the JMP
        step(1,1,1,1,9'h000,8'd0,   0,0,8'hFD,0,0,3);
        step(1,1,0,0,9'h182,8'd0,   1,1,8'h02,0,1,4);
        step(1,1,0,0,9'h140,8'd99,  0,0,8'h02,0,0,4);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'h02,0,0,4);
        // run gating mid-squash
        step(1,1,0,0,9'h140,8'd33,  1,0,8'd33,0,1,5);
        step(1,0,0,0,9'h000,8'd0,   0,0,8'd33,0,0,5);
        step(1,0,0,0,9'h140,8'd50,  0,0,8'd33,0,0,5);
        step(1,1,0,0,9'h140,8'd50,  0,0,8'd33,0,0,5);
        step(1,1,0,0,9'h140,8'd7,   1,0,8'd7,0,1,6);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'd7,0,0,6);
        // halt is sticky until reset
        step(1,1,0,0,9'h1FF,8'd0,   0,0,8'd7,1,1,6);
        step(1,1,0,0,9'h140,8'd1,   0,0,8'd7,1,1,6);
        step(1,1,1,1,9'h182,8'd0,   0,0,8'd7,1,1,6);
        step(1,0,0,0,9'h000,8'd0,   0,0,8'd7,1,0,6);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'd7,1,1,6);
        step(0,1,0,0,9'h140,8'd5,   0,0,8'h00,0,0,0);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'h00,0,0,0);
        step(1,1,0,0,9'h182,8'd0,   0,0,8'h00,0,0,0);
        // reset during squash kills the pulse
        step(1,1,0,0,9'h140,8'd20,  1,0,8'd20,0,1,1);
        step(0,1,0,0,9'h000,8'd0,   0,0,8'h00,0,0,0);
        step(1,1,0,0,9'h000,8'd0,   0,0,8'h00,0,0,0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_control.md
Name: branch_control

Overview:
- Consumes the instruction word from instructionFetch and drives that block's redirect inputs: _branchJump, _relative, _destBranchJump and _halt.
- Sits between fetch and execute. It decodes control-class instructions, holds the registered zero flag, issues one-cycle redirect pulses, and squashes the wrong-path instruction fetched during the redirect.
- Owns the HALT latch and a saturating taken-branch counter.

Parameters:
- INSN_WIDTH, 9, instruction width; must equal definitions::INSN_WIDTH.
- DATA_WIDTH, 8, target/offset width; must equal definitions::DATA_WIDTH.
- CNT_WIDTH, 16, width of the taken-branch counter.

Ports:
- _CLK  in  1  clock; all state changes on the rising edge.
- _reset  in  1  synchronous, active-low reset.
- _run  in  1  global run enable; when low, all state holds.
- instruction  in  INSN_WIDTH  current word from instructionFetch.
- _regData  in  DATA_WIDTH  register-file value, used as the absolute JMP target.
- _aluZero  in  1  zero result from the ALU.
- _flagWrite  in  1  load _aluZero into the flag register.
- _branchJump  out  1  redirect pulse to fetch.
- _relative  out  1  1 = target is a PC offset; 0 = target is absolute.
- _destBranchJump  out  DATA_WIDTH  target or offset, two's complement.
- _halt  out  1  stop fetch; sticky until reset.
- _squash  out  1  the current instruction is wrong-path; execute must treat it as NOP.
- takenCount  out  CNT_WIDTH  number of redirects issued, saturating.

Behaviour:
- Encoding: opcode = instruction[8:6]; imm6 = instruction[5:0].
  - OP_JMP (3'b101): absolute jump to _regData.
  - OP_BRZ (3'b110): relative branch by sign-extend(imm6), taken only if zFlag = 1.
  - OP_CTL (3'b111) with imm6 = 6'h3F: HALT.
  - OP_CTL with any other imm6, and every other opcode: not control; no action.
- Reset (_reset = 0 at an edge):
  - Outputs _branchJump, _relative, _halt, _squash = 0; _destBranchJump = 0; takenCount = 0.
  - zFlag = 0; state = RUN.
  - Reset wins over all other inputs, in any state.
- _run = 0: the FSM, flag and counter hold; _branchJump and _squash are forced to 0.
- All outputs are registered, so decode-to-redirect latency is 1 cycle.
- FSM states and transitions:
  - RUN, current instruction not squashed:
    - OP_JMP: next cycle drives _branchJump = 1, _relative = 0, _destBranchJump = _regData (sampled in the decode cycle); go to SQUASH.
    - OP_BRZ with zFlag = 1 (value before any same-cycle write): next cycle drives _branchJump = 1, _relative = 1, _destBranchJump = sign-extend(imm6); go to SQUASH.
    - OP_BRZ with zFlag = 0: no redirect; stay in RUN.
    - HALT: next cycle drives _halt = 1; go to HALTED.
  - SQUASH: lasts exactly 1 cycle.
    - _branchJump = 1 and _squash = 1; the instruction presented this cycle is ignored, including any control opcode.
    - Next edge: go to RUN with _branchJump = 0 and _relative = 0.
    - _destBranchJump holds its last value.
  - HALTED:
    - _halt stays 1 and _squash stays 1; all instructions are ignored.
    - Exited only by reset.
- Flag: zFlag <= _aluZero when _flagWrite = 1 and _run = 1.
  - Writes are allowed in every state except HALTED.
  - A BRZ decoded in the same cycle as a write uses the old flag.
- Counter: takenCount increments on each edge that enters SQUASH; it saturates at all-ones (no wrap).
- Back-to-back control instructions: the second is always in the squash shadow, so it is dropped.
- A reset asserted during SQUASH clears _branchJump in the same edge; no partial pulse survives.

Decomposition:
- Add to package definitions:
  - opcode constants OP_JMP, OP_BRZ, OP_CTL and HALT_IMM = 6'h3F;
  - typedef enum logic [1:0] bc_state_t {BC_RUN, BC_SQUASH, BC_HALTED};
  - field position constants for the opcode and imm6.
- One sub-module: sat_counter (parameterised width, synchronous clear, increment enable, saturate at max), reusable elsewhere.
- The decode and FSM stay in branch_control.

Test Plan:
- Reset and defaults: hold _reset = 0 for 2 cycles with instruction = 9'h1FF → all outputs 0 and takenCount = 0; then release _reset with _run = 1 and instruction = NOP → all outputs stay 0.
- Absolute jump: _regData = 8'd14, instruction = {3'b101, 6'd0} → the next cycle has _branchJump = 1, _relative = 0, _destBranchJump = 14, _squash = 1; the cycle after has _branchJump = 0; takenCount = 1.
- Relative branch:
  - _flagWrite = 1 with _aluZero = 1, then BRZ with imm6 = 6'h3D → _relative = 1, _destBranchJump = 8'hFD (−3).
  - Repeat with zFlag = 0 → no redirect and takenCount unchanged.
- Squash shadow: BRZ (taken) followed immediately by JMP → exactly one _branchJump pulse, and the JMP is ignored.
- Halt: instruction = 9'h1FF → the next cycle has _halt = 1 and _squash = 1; later JMPs have no effect; _reset = 0 clears _halt at the next edge.
- Run gating and saturation:
  - Drop _run mid-SQUASH → _branchJump drops to 0 and the state holds.
  - With CNT_WIDTH = 2, issue 5 taken branches → takenCount = 3.
